// File: rtl/tv_timing_pkg.sv
// tv_timing_pkg: line/frame timing constants and FSM encoding shared with the TV-out generator
package tv_timing_pkg;
  localparam int CLK_DIV = 5;
  localparam int H_START = 60;
  localparam int H_ACTIVE = 512;
  localparam int V_START = 18;
  localparam int V_ACTIVE = 287;
  localparam logic [11:0] HSYNC_MIN = 12'd150;
  localparam logic [11:0] HSYNC_MAX = 12'd350;
  localparam logic [11:0] VSYNC_MIN = 12'd2500;
  localparam logic [11:0] LINE_TIMEOUT = 12'd3500;
  localparam logic [8:0] V_LIMIT = 9'd320;
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
endpackage

// File: rtl/tv_sync_classifier.sv
// tv_sync_classifier: synchronizes sync/video and classifies sync low pulses by width
module tv_sync_classifier
  import tv_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sync_in_,
  input  logic vin,
  output logic sync,
  output logic video,
  output logic hsync_ev,
  output logic vsync_ev,
  output logic err_ev
);
  logic [2:0] sq;
  logic [1:0] vq;
  logic [11:0] width;
  logic rise;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sq <= '1;
      vq <= '0;
      width <= '0;
    end else begin
      sq <= {sq[1:0], sync_in_};
      vq <= {vq[0], vin};
      width <= sq[1] ? 12'd0 : (&width ? width : width + 12'd1);
    end
  assign rise = sq[1] & ~sq[2];
  assign hsync_ev = rise && width >= HSYNC_MIN && width <= HSYNC_MAX;
  assign vsync_ev = rise && width >= VSYNC_MIN;
  assign err_ev = rise && width > HSYNC_MAX && width < VSYNC_MIN;
  assign sync = sq[1];
  assign video = vq[1];
endmodule

// File: rtl/tv_capture.sv
// tv_capture: recovers composite-video timing and packs the active window into byte writes
module tv_capture
  import tv_timing_pkg::*;
#(
  parameter int ACT_X0 = H_START,
  parameter int ACT_W = H_ACTIVE,
  parameter int ACT_Y0 = V_START,
  parameter int ACT_H = V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_in_,
  input  logic        vin,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_start,
  output logic        locked
);
  localparam logic [9:0] HS = 10'(ACT_X0);
  localparam logic [9:0] HE = 10'(ACT_X0 + ACT_W);
  localparam logic [8:0] VS = 9'(ACT_Y0);
  localparam logic [8:0] VE = 9'(ACT_Y0 + ACT_H);
  localparam logic [2:0] PH_TICK = 3'(CLK_DIV / 2);
  localparam logic [2:0] PH_LAST = 3'(CLK_DIV - 1);
  logic sync, video, hsync_ev, vsync_ev, err_ev;
  state_t state;
  logic [2:0] phase;
  logic [9:0] hcount;
  logic [8:0] vcount, y;
  logic [8:0] x;
  logic [11:0] idle;
  logic [7:0] shreg;
  logic tick, act, last, timeout, lost;
  tv_sync_classifier u_cls (
    .clk(clk), .rst(rst), .sync_in_(sync_in_), .vin(vin), .sync(sync), .video(video),
    .hsync_ev(hsync_ev), .vsync_ev(vsync_ev), .err_ev(err_ev)
  );
  assign tick = phase == PH_TICK && !hsync_ev && !vsync_ev;
  assign x = 9'(hcount - HS);
  assign y = vcount - VS;
  assign act = state == LOCKED && tick && hcount >= HS && hcount < HE && vcount >= VS && vcount < VE;
  assign last = act && &x[2:0];
  // vsync lines carry no hsync, so the line timer only runs while sync is high
  assign timeout = idle >= LINE_TIMEOUT - 12'd1 && !hsync_ev;
  assign lost = err_ev || (!vsync_ev && (timeout || vcount > V_LIMIT));
  assign locked = state == LOCKED;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SEARCH;
      phase <= '0;
      hcount <= '0;
      vcount <= '0;
      idle <= '0;
      shreg <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_start <= 1'b0;
    end else begin
      state <= state == SEARCH ? (vsync_ev ? ALIGN : SEARCH)
             : state == ALIGN ? (hsync_ev ? LOCKED : ALIGN)
             : (lost ? SEARCH : LOCKED);
      phase <= (hsync_ev || vsync_ev || phase == PH_LAST) ? 3'd0 : phase + 3'd1;
      hcount <= hsync_ev ? 10'd0 : tick ? hcount + 10'd1 : hcount;
      vcount <= vsync_ev ? 9'd0 : hsync_ev ? vcount + 9'd1 : vcount;
      idle <= (hsync_ev || vsync_ev) ? 12'd0 : (sync && !(&idle)) ? idle + 12'd1 : idle;
      shreg <= act ? {shreg[6:0], video} : locked ? shreg : 8'd0;
      wr_en <= last;
      wr_data <= last ? {shreg[6:0], video} : wr_data;
      wr_addr <= last ? {y, x[8:3]} : wr_addr;
      frame_start <= act && x == 9'd0 && y == 9'd0;
    end
endmodule

// File: tb/tb_tv_capture.sv
// tb_tv_capture: randomized composite-video frames checked against a pixel-image reference
module tb_tv_capture;
  localparam int X0 = 8, W = 64, Y0 = 2, H = 4, NL = Y0 + H + 1;
  localparam int K_NORM = 0, K_GLITCH = 1, K_ERR = 2, K_TMO = 3, K_RST = 4;
  logic clk, rst, sync_in_, vin, wr_en, frame_start, locked;
  logic [14:0] wr_addr;
  logic [7:0] wr_data;
  logic [W-1:0] img [H];
  logic [7:0] ram [32768];
  int tests = 0, fails = 0, nw = 0, fs_cnt = 0;
  tv_capture #(.ACT_X0(X0), .ACT_W(W), .ACT_Y0(Y0), .ACT_H(H)) dut (
    .clk(clk), .rst(rst), .sync_in_(sync_in_), .vin(vin), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_start(frame_start), .locked(locked)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] expb(input int yy, input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[7-b] = img[yy][8*k+b];
    return r;
  endfunction
  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      nw = 0;
    end
    if (wr_en) begin
      check("wr_addr", 32'(wr_addr), 32'((nw / (W/8)) * 64 + nw % (W/8)));
      check("wr_data", 32'(wr_data), 32'(expb(nw / (W/8), nw % (W/8))));
      ram[wr_addr] = wr_data;
      nw++;
    end
  end
  task automatic line(input int n, input int kind);
    int len;
    bit lo;
    len = n == 0 ? 3000 : kind == K_ERR ? 1740 : kind == K_TMO ? 4240 : 640;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (kind == K_ERR && c == 1642) check("err_locked_before", 32'(locked), 1);
      if (kind == K_ERR && c == 1643) check("err_locked_after", 32'(locked), 0);
      if (kind == K_TMO && c == 3742) check("tmo_locked_before", 32'(locked), 1);
      if (kind == K_TMO && c == 3743) check("tmo_locked_after", 32'(locked), 0);
      if (kind == K_RST && c == 385) begin
        rst = 1;
        #1;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_locked", 32'(locked), 0);
      end
      if (kind == K_RST && c == 388) rst = 0;
      lo = n == 0 ? c < 2600 : (c < 240 || (kind == K_GLITCH && c >= 400 && c < 500)
                                || (kind == K_ERR && c >= 640 && c < 1640));
      sync_in_ = !lo;
      vin = (n >= Y0 && n < Y0 + H && c >= 280 && c < 280 + 5*W) ? img[n-Y0][(c-280)/5] : 1'($urandom);
    end
  endtask
  task automatic frame(input int sel, input int kind, input int exp_nw, input bit border, input bit exp_lock);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        img[yy][xx] = border ? (xx == 3 || xx == 13 || xx == 50 || xx == 60 || yy == 1 || yy == 3)
                             : 1'($urandom);
    fs_cnt = 0;
    line(0, K_NORM);
    for (int n = 1; n <= NL; n++) begin
      line(n, n == sel ? kind : K_NORM);
      if (n == sel && kind == K_TMO) break;
    end
    check("frame_start_count", 32'(fs_cnt), 1);
    check("writes_per_frame", 32'(nw), 32'(exp_nw));
    check("locked_end", 32'(locked), 32'(exp_lock));
  endtask
  initial begin
    rst = 1;
    sync_in_ = 1;
    vin = 0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_wr_data", 32'(wr_data), 0);
    check("reset_frame_start", 32'(frame_start), 0);
    check("reset_locked", 32'(locked), 0);
    rst = 0;
    repeat (20) @(negedge clk);
    check("search_locked", 32'(locked), 0);
    frame(0, K_NORM, H*W/8, 1, 1);
    check("ram_0", 32'(ram[0]), 32'h10);
    check("ram_64", 32'(ram[64]), 32'hff);
    check("ram_6", 32'(ram[6]), 32'h20);
    check("ram_7", 32'(ram[7]), 32'h08);
    check("ram_129", 32'(ram[129]), 32'h04);
    frame(3, K_ERR, 16, 0, 0);
    frame(4, K_GLITCH, H*W/8, 0, 1);
    frame(3, K_TMO, 16, 0, 0);
    repeat (3) @(negedge clk) begin
      sync_in_ = 1;
      vin = 1'($urandom);
    end
    frame(0, K_NORM, H*W/8, 0, 1);
    frame(3, K_RST, 10, 0, 0);
    frame(0, K_NORM, H*W/8, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
